// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN encoder stages.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GEN,
        ST_OUT,
        ST_FIN
    } enc_state_e;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam int unsigned DEF_N_INPUTS = 16;
    localparam int unsigned DEF_T_STEPS  = 8;

    // One step of the right-shifting Galois LFSR (x^16+x^14+x^13+x^11).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous load and enable; load wins over enable.
module lfsr16
    import snn_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next-state selection: reload, advance, or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed;
        end else if (en) begin
            lfsr_d = lfsr16_next(lfsr_q);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Bernoulli rate encoder: loads a pixel frame, emits T_STEPS spike vectors over valid/ready.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int unsigned N_INPUTS  = DEF_N_INPUTS,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned T_STEPS   = DEF_T_STEPS,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_en,
    output logic [$clog2(N_INPUTS)-1:0]  pix_addr,
    input  logic [PIX_W-1:0]             pix_data,
    output logic [N_INPUTS-1:0]          spike_vec,
    output logic                         spike_valid,
    input  logic                         spike_ready,
    output logic [$clog2(T_STEPS)-1:0]   timestep,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned AW = $clog2(N_INPUTS);
    localparam int unsigned TW = $clog2(T_STEPS);
    localparam int unsigned CW = $clog2(N_INPUTS + 1);

    enc_state_e             state_q, state_d;
    logic                   start_q, start_d;
    logic [CW-1:0]          ld_cnt_q, ld_cnt_d;
    logic [AW-1:0]          pix_addr_q, pix_addr_d;
    logic [AW-1:0]          gen_idx_q, gen_idx_d;
    logic [PIX_W-1:0]       pix_reg_q [N_INPUTS];
    logic [PIX_W-1:0]       pix_reg_d [N_INPUTS];
    logic [N_INPUTS-1:0]    shadow_q, shadow_d;
    logic [N_INPUTS-1:0]    spike_vec_q, spike_vec_d;
    logic                   spike_valid_q, spike_valid_d;
    logic [TW-1:0]          ts_q, ts_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   start_pulse;
    logic                   lfsr_load;
    logic                   lfsr_en;
    logic [15:0]            lfsr_val;
    logic                   lfsr_unused_c;

    assign start_pulse   = start_en & ~start_q;
    assign lfsr_unused_c = ^lfsr_val[15:PIX_W];

    lfsr16 #(
        .RESET_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .seed  (LFSR_SEED),
        .en    (lfsr_en),
        .q     (lfsr_val)
    );

    // Next-state and output computation for the encoder FSM.
    always_comb begin
        state_d       = state_q;
        start_d       = start_en;
        ld_cnt_d      = ld_cnt_q;
        pix_addr_d    = pix_addr_q;
        gen_idx_d     = gen_idx_q;
        pix_reg_d     = pix_reg_q;
        shadow_d      = shadow_q;
        spike_vec_d   = spike_vec_q;
        spike_valid_d = spike_valid_q;
        ts_d          = ts_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        lfsr_load     = 1'b0;
        lfsr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    lfsr_load  = 1'b1;
                    ld_cnt_d   = '0;
                    pix_addr_d = '0;
                    gen_idx_d  = '0;
                    ts_d       = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Read data lags the address by one cycle.
                if (ld_cnt_q != '0) begin
                    pix_reg_d[AW'(ld_cnt_q - CW'(1))] = pix_data;
                end
                if (ld_cnt_q == CW'(N_INPUTS)) begin
                    gen_idx_d = '0;
                    shadow_d  = '0;
                    state_d   = ST_GEN;
                end else begin
                    ld_cnt_d   = ld_cnt_q + CW'(1);
                    pix_addr_d = (ld_cnt_q < CW'(N_INPUTS - 1)) ? AW'(ld_cnt_q + CW'(1))
                                                                : AW'(N_INPUTS - 1);
                end
            end
            ST_GEN: begin
                lfsr_en             = 1'b1;
                shadow_d[gen_idx_q] = (pix_reg_q[gen_idx_q] > lfsr_val[PIX_W-1:0]);
                if (gen_idx_q == AW'(N_INPUTS - 1)) begin
                    spike_vec_d   = shadow_d;
                    spike_valid_d = 1'b1;
                    state_d       = ST_OUT;
                end else begin
                    gen_idx_d = gen_idx_q + AW'(1);
                end
            end
            ST_OUT: begin
                if (spike_ready) begin
                    spike_valid_d = 1'b0;
                    if (ts_q == TW'(T_STEPS - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        ts_d      = ts_q + TW'(1);
                        gen_idx_d = '0;
                        shadow_d  = '0;
                        state_d   = ST_GEN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            ld_cnt_q      <= '0;
            pix_addr_q    <= '0;
            gen_idx_q     <= '0;
            for (int i = 0; i < int'(N_INPUTS); i++) begin
                pix_reg_q[i] <= '0;
            end
            shadow_q      <= '0;
            spike_vec_q   <= '0;
            spike_valid_q <= 1'b0;
            ts_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            ld_cnt_q      <= ld_cnt_d;
            pix_addr_q    <= pix_addr_d;
            gen_idx_q     <= gen_idx_d;
            pix_reg_q     <= pix_reg_d;
            shadow_q      <= shadow_d;
            spike_vec_q   <= spike_vec_d;
            spike_valid_q <= spike_valid_d;
            ts_q          <= ts_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign pix_addr    = pix_addr_q;
    assign spike_vec   = spike_vec_q;
    assign spike_valid = spike_valid_q;
    assign timestep    = ts_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: bench LFSR model predicts every vector.
module tb_spike_rate_encoder;

    localparam int unsigned N    = 16;
    localparam int unsigned T    = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_en;
    logic [3:0]  pix_addr;
    logic [7:0]  pix_data;
    logic [15:0] spike_vec;
    logic        spike_valid;
    logic        spike_ready;
    logic [2:0]  timestep;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    spike_rate_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .start_en    (start_en),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .spike_vec   (spike_vec),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .timestep    (timestep),
        .busy        (busy),
        .done        (done)
    );

    // Input buffer: one-cycle read latency.
    logic [7:0] mem [N];
    always @(posedge clk) pix_data <= mem[pix_addr];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [18:0] sb [$];
    time         t_start;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] s;
        s = {1'b0, x[15:1]};
        if (x[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Predict a full run from the current buffer contents.
    task automatic push_model();
        logic [15:0] l;
        logic [15:0] v;
        l = SEED;
        for (int t = 0; t < int'(T); t++) begin
            v = '0;
            for (int i = 0; i < int'(N); i++) begin
                v[i] = (mem[i] > l[7:0]);
                l = lfsr_step(l);
            end
            sb.push_back({3'(t), v});
        end
    endtask

    task automatic kick();
        push_model();
        start_en = 1'b1;
        t_start  = $time;
        @(negedge clk);
        start_en = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(N); i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    // Monitor: pop and compare each transferred vector until done, bounded.
    task automatic drain(input int mode, output int lat, output int gap);
        int  n_xfer;
        time t_first;
        bit  fin;
        logic [18:0] e;
        n_xfer = 0; t_first = 0; fin = 1'b0; lat = -1; gap = -1;
        for (int c = 0; c < 3000 && !fin; c++) begin
            spike_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (spike_valid && lat < 0) lat = int'(($time - t_start) / 10);
            if (spike_valid && spike_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_vector: got ts=%0d vec=%h, required none", timestep, spike_vec);
                end else begin
                    e = sb.pop_front();
                    if ({timestep, spike_vec} !== e) begin
                        miscompares++;
                        $display("FAIL vector: got ts=%0d vec=%h, required ts=%0d vec=%h",
                                 timestep, spike_vec, e[18:16], e[15:0]);
                    end
                end
                n_xfer++;
                if (n_xfer == 1) t_first = $time;
                if (n_xfer == 2) gap = int'(($time - t_first) / 10);
            end
            if (done) begin
                fin = 1'b1;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_at_done: got %b, required 0", busy);
                end
                vectors++;
                if (sb.size() != 0) begin
                    miscompares++;
                    $display("FAIL missing_vectors: got %0d left, required 0", sb.size());
                end
            end
            @(negedge clk);
        end
        spike_ready = 1'b1;
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL done_timeout: got no done, required done");
        end else if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_width: got %b one cycle later, required 0", done);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({pix_addr, spike_vec, spike_valid, timestep, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL %s: got addr=%h vec=%h valid=%b ts=%0d busy=%b done=%b, required all 0",
                     name, pix_addr, spike_vec, spike_valid, timestep, busy, done);
        end
    endtask

    task automatic test_reset();
        int lat, gap;
        reset = 1'b1; start_en = 1'b0; spike_ready = 1'b0;
        for (int i = 0; i < int'(N); i++) mem[i] = 8'(i * 13 + 7);
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_init");
        reset = 1'b0;
        @(negedge clk);
        kick();
        spike_ready = 1'b1;
        repeat (24) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_midgen_1");
        @(negedge clk);
        check_idle_outputs("reset_midgen_2");
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_idle_outputs("reset_released");
        kick();
        drain(1, lat, gap);
    endtask

    task automatic test_zeros();
        int lat, gap;
        for (int i = 0; i < int'(N); i++) mem[i] = 8'h00;
        kick();
        drain(1, lat, gap);
        vectors++;
        if (lat != 34) begin
            miscompares++;
            $display("FAIL first_latency: got %0d, required 34", lat);
        end
        vectors++;
        if (gap != 17) begin
            miscompares++;
            $display("FAIL step_period: got %0d, required 17", gap);
        end
    endtask

    task automatic test_full();
        int lat, gap;
        for (int i = 0; i < int'(N); i++) mem[i] = 8'hFF;
        kick();
        drain(1, lat, gap);
    endtask

    task automatic test_ramp();
        int lat, gap;
        for (int i = 0; i < int'(N); i++) mem[i] = 8'(16 * i);
        for (int r = 0; r < 3; r++) begin
            kick();
            drain(r == 1 ? 2 : 1, lat, gap);
        end
    endtask

    task automatic test_random_ready();
        int lat, gap;
        fill_random();
        kick();
        drain(2, lat, gap);
    endtask

    task automatic test_backpressure();
        int lat, gap;
        bit hit;
        logic [18:0] e;
        fill_random();
        kick();
        hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            if (spike_valid && timestep == 3'd3) begin
                hit = 1'b1;
            end else begin
                spike_ready = 1'b1;
                if (spike_valid) begin
                    e = sb.pop_front();
                    vectors++;
                    if ({timestep, spike_vec} !== e) begin
                        miscompares++;
                        $display("FAIL bp_pre_vector: got ts=%0d vec=%h, required ts=%0d vec=%h",
                                 timestep, spike_vec, e[18:16], e[15:0]);
                    end
                end
                @(negedge clk);
            end
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL bp_reach_ts3: got no timestep 3, required timestep 3");
        end else begin
            spike_ready = 1'b0;
            e = sb[0];
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                vectors++;
                if ({spike_valid, timestep, spike_vec} !== {1'b1, e}) begin
                    miscompares++;
                    $display("FAIL bp_hold: got valid=%b ts=%0d vec=%h, required valid=1 ts=%0d vec=%h",
                             spike_valid, timestep, spike_vec, e[18:16], e[15:0]);
                end
            end
        end
        drain(1, lat, gap);
    endtask

    task automatic test_start_level();
        int lat, gap, elapsed;
        bit quiet;
        fill_random();
        push_model();
        start_en = 1'b1;
        t_start  = $time;
        @(negedge clk);
        drain(1, lat, gap);
        elapsed = int'(($time - t_start) / 10);
        quiet = 1'b1;
        for (int c = elapsed; c < 200; c++) begin
            if (busy || spike_valid || done) quiet = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL level_restart: got activity after done, required idle");
        end
        start_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, gap;
        fill_random();
        kick();
        @(negedge clk);
        start_en = 1'b1;
        @(negedge clk);
        start_en = 1'b0;
        drain(1, lat, gap);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_pulse_queued: got busy=%b after done, required 0", busy);
        end
        fill_random();
        kick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_after_done: got busy=%b, required 1", busy);
        end
        drain(1, lat, gap);
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_full();
        test_ramp();
        test_random_ready();
        test_backpressure();
        test_start_level();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
